fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Shares the single write port of one of the team's FIFOs (async or first-word-fall-through) between several producers in the FIFO's write-clock domain. Each producer gets the port in round-robin order for a bounded burst. The arbiter honours the FIFO's `full` and `prog_full` flags, so no word is ever dropped or written into a full FIFO. It sits directly in front of the FIFO's `wr_en`/`din`/`full`/`prog_full` pins.

## Interface
- `NUM_REQ`, 4: number of requesters, at least 2.
- `DATA_WIDTH`, 64: word width; equals the FIFO's `WR_DATA_WIDTH`.
- `BURST_LEN`, 16: maximum beats per grant, at least 1.

- `sys_clk`  in  1  single clock, the FIFO write clock.
- `global_rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `req_valid`  in  NUM_REQ  per-requester word available.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  per-requester word accepted this cycle when it coincides with `req_valid`.
- `fifo_wr_en`  out  1  to FIFO `wr_en`.
- `fifo_din`  out  DATA_WIDTH  to FIFO `din`.
- `fifo_full`  in  1  from FIFO `full`.
- `fifo_prog_full`  in  1  from FIFO `prog_full`.
- `grant`  out  NUM_REQ  registered one-hot owner; all zero when idle.
- `busy`  out  1  high while in XFER.

## Operation
- FSM has two states.
  - **IDLE:** if any `req_valid` is high and `fifo_prog_full`=0, select the first requester with `req_valid` high, searching from `last+1` modulo NUM_REQ. Register that requester into `grant`, set `last` to it, clear `beat_cnt`, go to XFER. Otherwise stay in IDLE.
  - **XFER:** `req_ready` = `grant` & {NUM_REQ{~fifo_full}}. `fifo_wr_en` = (state==XFER) & `req_valid[g]` & ~`fifo_full`. `fifo_din` = `req_data` slice g, always muxed by the registered `grant`. Each beat (`fifo_wr_en`=1) increments `beat_cnt`.
- XFER exits to IDLE (`grant` cleared) at the clock edge where either condition holds:
  - a beat occurs with `beat_cnt`==BURST_LEN-1;
  - `req_valid[g]`=0 (the requester has gone idle).
- `fifo_full` during XFER only stalls; it never ends the burst.
- `fifo_prog_full` blocks new grants only; a burst already in progress continues, gated by `fifo_full`.
- A requester whose valid drops mid-burst loses the remainder of its grant. Its next grant comes through normal round-robin.
- Requester data ordering is preserved; the arbiter holds no storage.
- `beat_cnt` is $clog2(BURST_LEN+1) bits wide and cannot overflow, because the exit condition fires at BURST_LEN-1.
- Reset state: state IDLE, `grant`=0, `busy`=0, `beat_cnt`=0, `last`=NUM_REQ-1, so requester 0 wins first. Combinational outputs follow: `fifo_wr_en`=0, `req_ready`=0.

## Timing
- Request to grant: `req_valid` sampled in IDLE, `grant`/`busy` high the next cycle, first beat in that same cycle if `fifo_full`=0.
- Throughput: one beat per cycle during XFER while valid and not full. Exactly one IDLE cycle between consecutive bursts, including back-to-back grants to the same requester.
- `fifo_full` to `fifo_wr_en`: combinational, zero cycles. This meets the FIFO's rule that `wr_en` must not be high while `full` is high.
- Reset mid-burst: `global_rst` high forces IDLE immediately, asynchronously. `fifo_wr_en` and `req_ready` fall within the same cycle, and no further beat is written. The partially sent burst is not resumed.
- Simultaneous events:
  - A last beat coinciding with `req_valid` loss ends the burst once, in the normal way.
  - `fifo_prog_full` rising in the same cycle as an IDLE arbitration blocks the grant.

## Structure
- Shared package `fifo_ctrl_pkg` holds:
  - the state encoding localparams (IDLE=0, XFER=1);
  - a function for the rotate-and-priority-encode round-robin pick, reused by future read-side schedulers.
- One sub-module is natural: `rr_pick`, a purely combinational round-robin selector with inputs `req`[NUM_REQ] and `last`, and outputs `onehot` and index.
- The FSM, `beat_cnt`, `last` register and data mux stay in `fifo_wr_arbiter`.

## Test plan
All scenarios use NUM_REQ=4, DATA_WIDTH=64, BURST_LEN=16, and a 1024-deep FIFO model or the real FIFO.
- Reset: hold `global_rst` high for 100 ns with all requesters valid. Required: `grant`=0, `busy`=0, `fifo_wr_en`=0, `req_ready`=0 throughout.
- Single requester 2 streams 40 words with values 0..39. Required:
  - bursts of 16, 16 and 8 beats;
  - exactly one idle cycle between bursts;
  - FIFO readback equals 0..39 in order.
- All four valid continuously, each with an incrementing counter. Required:
  - `grant` sequence 0001, 0010, 0100, 1000, 0001;
  - 16 beats each;
  - no skipped or duplicated values per requester.
- `fifo_full` forced high for 3 cycles at beat 5 of a burst. Required:
  - `fifo_wr_en` and `req_ready` low in those exact cycles;
  - burst still totals 16 beats;
  - no data lost.
- `fifo_prog_full` high while requester 1 is valid in IDLE. Required: no grant. Drop `fifo_prog_full`; then `grant`=0010 on the next cycle.
- Assert `global_rst` at beat 7 of a grant to requester 3. Required:
  - `fifo_wr_en` drops the same cycle;
  - after release with all requesters valid, the first grant is 0001.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO-side controllers: FSM state encoding and the
// round-robin pick function used by write arbiters and future read schedulers.
package fifo_ctrl_pkg;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_XFER = 1'b1;

  typedef enum logic {
    IDLE = STATE_IDLE,
    XFER = STATE_XFER
  } arb_state_e;

  // Widest requester vector the pick function handles.
  localparam int RR_MAX_REQ = 32;
  localparam int RR_IDX_W   = 5;

  // Returns the first set bit of req searching from last+1 modulo num_req,
  // or -1 when no bit in req[num_req-1:0] is set.
  function automatic int rr_pick_idx(input logic [RR_MAX_REQ-1:0] req,
                                     input int num_req,
                                     input int last);
    int pick;
    int cand;
    pick = -1;
    for (int k = 1; k <= RR_MAX_REQ; k++) begin
      if (k <= num_req) begin
        cand = last + k;
        if (cand >= num_req) cand = cand - num_req;
        if (pick < 0 && req[cand[RR_IDX_W-1:0]]) pick = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Purely combinational round-robin selector: first requester after `last`.
module rr_pick
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [RR_MAX_REQ-1:0] req_ext;
  int                    pick;

  always_comb begin
    req_ext = RR_MAX_REQ'(req);
    pick    = rr_pick_idx(req_ext, NUM_REQ, int'(last));
    found   = (pick >= 0);
    idx     = IDX_W'(pick);
    onehot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      onehot[i] = found && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ
// producers; honours full (stall) and prog_full (no new grants).
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 16
) (
  input  logic                          sys_clk,
  input  logic                          global_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  input  logic                          fifo_full,
  input  logic                          fifo_prog_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

  arb_state_e         state;
  logic [IDX_W-1:0]   last;
  logic [CNT_W-1:0]   beat_cnt;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               grant_valid;
  logic               beat;
  logic               burst_done;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req    (req_valid),
    .last   (last),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      fifo_din |= req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}};
    end
  end

  // grant is all-zero in IDLE, so these gate themselves off outside a burst.
  assign grant_valid = |(req_valid & grant);
  assign beat        = (state == XFER) && grant_valid && !fifo_full;
  assign fifo_wr_en  = beat;
  assign req_ready   = grant & {NUM_REQ{~fifo_full}};
  assign burst_done  = !grant_valid || (beat && (beat_cnt == LAST_BEAT));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is asynchronous so outputs drop at once.
  always_ff @(posedge sys_clk or posedge global_rst) begin
    if (global_rst) begin
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      beat_cnt <= '0;
      last     <= LAST_RESET;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_found && !fifo_prog_full) begin
            state    <= XFER;
            grant    <= pick_onehot;
            busy     <= 1'b1;
            last     <= pick_idx;
            beat_cnt <= '0;
          end
        end
        XFER: begin
          if (burst_done) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            beat_cnt <= '0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
